// File: rtl/pc_unit_pkg.sv
// Shared encodings for the program-counter unit: next-PC selects,
// exception FSM states and default vector addresses.
package pc_unit_pkg;

    localparam logic [2:0] NPC_SEQ = 3'd0;
    localparam logic [2:0] NPC_BR  = 3'd1;
    localparam logic [2:0] NPC_J   = 3'd2;
    localparam logic [2:0] NPC_JAL = 3'd3;
    localparam logic [2:0] NPC_JR  = 3'd4;

    localparam logic [0:0] ST_NORM = 1'b0;
    localparam logic [0:0] ST_EXC  = 1'b1;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0180;

endpackage

// File: rtl/pc_unit_if.sv
// Bundle between control FSM / datapath / CP0 and the PC unit.
// master = the surrounding CPU, slave = pc_unit.
interface pc_unit_if #(parameter int AW = 32);

    logic          pc_wr;
    logic [2:0]    npc_sel;
    logic [15:0]   imm16;
    logic [25:0]   target26;
    logic [AW-1:0] jr_addr;
    logic          exc_req;
    logic          eret;

    logic [AW-1:0] pc;
    logic [AW-1:0] pc_plus4;
    logic [AW-1:0] epc;
    logic          exl;
    logic [AW-1:0] ras_top;
    logic          ras_valid;
    logic          addr_err;

    modport master (
        output pc_wr, npc_sel, imm16, target26, jr_addr, exc_req, eret,
        input  pc, pc_plus4, epc, exl, ras_top, ras_valid, addr_err
    );

    modport slave (
        input  pc_wr, npc_sel, imm16, target26, jr_addr, exc_req, eret,
        output pc, pc_plus4, epc, exl, ras_top, ras_valid, addr_err
    );

endinterface

// File: rtl/pc_unit_ras.sv
// Return-address stack: circular buffer with pointer and occupancy count.
// A push into a full stack overwrites the oldest entry; a pop on an empty
// stack does nothing. Popped entries are not cleared, only the count moves.
module pc_ras #(
    parameter int AW        = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top,
    output logic          valid
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(RAS_DEPTH);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1'b1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);

    logic [AW-1:0] mem_r [RAS_DEPTH];
    logic [PW-1:0] ptr_r;
    logic [PW:0]   count_r;
    logic [AW-1:0] top_s;

    // Stack storage, write pointer and occupancy; push has priority over pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_r[i] <= {AW{1'b0}};
            end
            ptr_r   <= {PW{1'b0}};
            count_r <= {(PW+1){1'b0}};
        end else if (push) begin
            mem_r[ptr_r] <= push_data;
            ptr_r        <= ptr_r + PTR_ONE;
            if (count_r != DEPTH_C) begin
                count_r <= count_r + CNT_ONE;
            end
        end else if (pop && (count_r != {(PW+1){1'b0}})) begin
            ptr_r   <= ptr_r - PTR_ONE;
            count_r <= count_r - CNT_ONE;
        end
    end

    // Most recent entry, forced to zero while the stack is empty.
    always_comb begin
        top_s = {AW{1'b0}};
        if (count_r != {(PW+1){1'b0}}) begin
            top_s = mem_r[ptr_r - PTR_ONE];
        end else begin
            top_s = {AW{1'b0}};
        end
    end

    assign top   = top_s;
    assign valid = (count_r != {(PW+1){1'b0}});

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, PC/EPC registers, exception
// mode FSM (NORM/EXC), sticky JR misalignment flag and a return-address
// stack that is a prediction hint only (PC is never loaded from it).
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int            AW        = 32,
    parameter logic [AW-1:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [AW-1:0] EXC_VEC   = DEF_EXC_VEC,
    parameter int            RAS_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    pc_unit_if.slave bus
);

    localparam logic [AW-1:0] FOUR_C      = {{(AW-3){1'b0}}, 3'b100};
    localparam logic [AW-1:0] RESET_PC_C  = {RESET_VEC[AW-1:2], 2'b00};
    localparam logic [AW-1:0] EXC_PC_C    = {EXC_VEC[AW-1:2], 2'b00};

    logic [AW-1:0] pc_r, epc_r;
    logic [0:0]    state_r;
    logic          aerr_r;

    logic [AW-1:0] pc_nxt_s, epc_nxt_s;
    logic [0:0]    state_nxt_s;
    logic          aerr_nxt_s;
    logic          push_s, pop_s;

    logic [AW-1:0] pc_plus4_s, br_tgt_s, j_tgt_s, jr_tgt_s;

    assign pc_plus4_s = pc_r + FOUR_C;
    assign br_tgt_s   = pc_plus4_s + {{(AW-18){bus.imm16[15]}}, bus.imm16, 2'b00};
    assign jr_tgt_s   = {bus.jr_addr[AW-1:2], 2'b00};

    // Jump region bits come from pc+4 only when the address is wider than the target field.
    generate
        if (AW > 28) begin : g_jwide
            assign j_tgt_s = {pc_plus4_s[AW-1:28], bus.target26, 2'b00};
        end else begin : g_jnarrow
            assign j_tgt_s = {bus.target26, 2'b00};
        end
    endgenerate

    // Next-state selection: exception entry, then ERET, then normal PC write.
    always_comb begin
        pc_nxt_s    = pc_r;
        epc_nxt_s   = epc_r;
        state_nxt_s = state_r;
        aerr_nxt_s  = aerr_r;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        if (bus.exc_req) begin
            pc_nxt_s    = EXC_PC_C;
            state_nxt_s = ST_EXC;
            if (state_r == ST_NORM) begin
                epc_nxt_s = pc_r;
            end else begin
                epc_nxt_s = epc_r;
            end
        end else if (bus.eret && (state_r == ST_EXC)) begin
            pc_nxt_s    = epc_r;
            state_nxt_s = ST_NORM;
        end else if (bus.pc_wr) begin
            case (bus.npc_sel)
                NPC_SEQ: pc_nxt_s = pc_plus4_s;
                NPC_BR:  pc_nxt_s = br_tgt_s;
                NPC_J:   pc_nxt_s = j_tgt_s;
                NPC_JAL: begin
                    pc_nxt_s = j_tgt_s;
                    push_s   = 1'b1;
                end
                NPC_JR: begin
                    pc_nxt_s = jr_tgt_s;
                    pop_s    = 1'b1;
                    if (bus.jr_addr[1:0] != 2'b00) begin
                        aerr_nxt_s = 1'b1;
                    end else begin
                        aerr_nxt_s = aerr_r;
                    end
                end
                default: pc_nxt_s = pc_r;
            endcase
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // Architectural registers: PC, EPC, exception mode and sticky address error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r    <= RESET_PC_C;
            epc_r   <= {AW{1'b0}};
            state_r <= ST_NORM;
            aerr_r  <= 1'b0;
        end else begin
            pc_r    <= pc_nxt_s;
            epc_r   <= epc_nxt_s;
            state_r <= state_nxt_s;
            aerr_r  <= aerr_nxt_s;
        end
    end

    pc_ras #(
        .AW        (AW),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_plus4_s),
        .top       (bus.ras_top),
        .valid     (bus.ras_valid)
    );

    assign bus.pc       = pc_r;
    assign bus.pc_plus4 = pc_plus4_s;
    assign bus.epc      = epc_r;
    assign bus.exl      = state_r[0];
    assign bus.addr_err = aerr_r;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus pushes cycle-tagged expected
// states, a negedge monitor pops and compares them against the outputs.
module tb_pc_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc_cnt = 0;
    int   total = 0;
    int   bad = 0;

    pc_unit_if #(.AW(32)) bus ();

    pc_unit #(
        .AW        (32),
        .RESET_VEC (32'h0000_0040),
        .EXC_VEC   (32'h0000_0180),
        .RAS_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        int          cyc;
        string       nm;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        exl;
        logic [31:0] top;
        logic        valid;
        logic        aerr;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endtask

    // Monitor: compare every expectation due at this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
            cur = exp_q.pop_front();
            if (cur.cyc < cyc_cnt) begin
                chk(cur.nm, "stale", 32'(cyc_cnt), 32'(cur.cyc));
            end else begin
                chk(cur.nm, "pc", bus.pc, cur.pc);
                chk(cur.nm, "pc_plus4", bus.pc_plus4, cur.pc + 32'd4);
                chk(cur.nm, "epc", bus.epc, cur.epc);
                chk(cur.nm, "exl", {31'd0, bus.exl}, {31'd0, cur.exl});
                chk(cur.nm, "ras_top", bus.ras_top, cur.top);
                chk(cur.nm, "ras_valid", {31'd0, bus.ras_valid}, {31'd0, cur.valid});
                chk(cur.nm, "addr_err", {31'd0, bus.addr_err}, {31'd0, cur.aerr});
            end
        end
    end

    task automatic push_exp(input string nm, input int cyc, input logic [31:0] e_pc, input logic [31:0] e_epc,
                            input logic e_exl, input logic [31:0] e_top, input logic e_v, input logic e_ae);
        exp_t e;
        e.cyc = cyc; e.nm = nm; e.pc = e_pc; e.epc = e_epc; e.exl = e_exl;
        e.top = e_top; e.valid = e_v; e.aerr = e_ae;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.pc_wr = 1'b0; bus.npc_sel = 3'd0; bus.imm16 = 16'h0; bus.target26 = 26'h0;
        bus.jr_addr = 32'h0; bus.exc_req = 1'b0; bus.eret = 1'b0;
    endtask

    // One clocked vector; called at posedge+1, returns at next posedge+1 with inputs idle.
    task automatic step(input string nm, input logic pw, input logic [2:0] sel, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic [31:0] jra, input logic exc, input logic er,
                        input logic [31:0] e_pc, input logic [31:0] e_epc, input logic e_exl,
                        input logic [31:0] e_top, input logic e_v, input logic e_ae);
        bus.pc_wr = pw; bus.npc_sel = sel; bus.imm16 = imm; bus.target26 = tgt;
        bus.jr_addr = jra; bus.exc_req = exc; bus.eret = er;
        push_exp(nm, cyc_cnt + 1, e_pc, e_epc, e_exl, e_top, e_v, e_ae);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push_exp("reset", cyc_cnt, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        //   name         pw  sel   imm       tgt       jr_addr        exc  eret  pc             epc        exl  top        v    ae
        step("jr100",     1, 3'd4, 16'h0,    26'h0,    32'h0000_0100, 0, 0, 32'h0000_0100, 32'h0,     0, 32'h0,     0, 0);
        step("br_neg",    1, 3'd1, 16'hFFFE, 26'h0,    32'h0,         0, 0, 32'h0000_00FC, 32'h0,     0, 32'h0,     0, 0);
        step("jr_top",    1, 3'd4, 16'h0,    26'h0,    32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 32'h0,     0, 32'h0,     0, 0);
        step("seq_wrap",  1, 3'd0, 16'h0,    26'h0,    32'h0,         0, 0, 32'h0000_0000, 32'h0,     0, 32'h0,     0, 0);
        step("hold",      0, 3'd3, 16'h0,    26'h3F,   32'h0,         0, 0, 32'h0000_0000, 32'h0,     0, 32'h0,     0, 0);
        step("rsvd5",     1, 3'd5, 16'h0,    26'h0,    32'h0,         0, 0, 32'h0000_0000, 32'h0,     0, 32'h0,     0, 0);
        step("jr200",     1, 3'd4, 16'h0,    26'h0,    32'h0000_0200, 0, 0, 32'h0000_0200, 32'h0,     0, 32'h0,     0, 0);
        step("jal1",      1, 3'd3, 16'h0,    26'h10,   32'h0,         0, 0, 32'h0000_0040, 32'h0,     0, 32'h204,   1, 0);
        step("jal2",      1, 3'd3, 16'h0,    26'h20,   32'h0,         0, 0, 32'h0000_0080, 32'h0,     0, 32'h44,    1, 0);
        step("jal3",      1, 3'd3, 16'h0,    26'h30,   32'h0,         0, 0, 32'h0000_00C0, 32'h0,     0, 32'h84,    1, 0);
        step("jal4",      1, 3'd3, 16'h0,    26'h40,   32'h0,         0, 0, 32'h0000_0100, 32'h0,     0, 32'hC4,    1, 0);
        step("jal5_full", 1, 3'd3, 16'h0,    26'h50,   32'h0,         0, 0, 32'h0000_0140, 32'h0,     0, 32'h104,   1, 0);
        step("pop1",      1, 3'd4, 16'h0,    26'h0,    32'h0000_0400, 0, 0, 32'h0000_0400, 32'h0,     0, 32'hC4,    1, 0);
        step("pop2",      1, 3'd4, 16'h0,    26'h0,    32'h0000_0404, 0, 0, 32'h0000_0404, 32'h0,     0, 32'h84,    1, 0);
        step("pop3",      1, 3'd4, 16'h0,    26'h0,    32'h0000_0408, 0, 0, 32'h0000_0408, 32'h0,     0, 32'h44,    1, 0);
        step("pop4",      1, 3'd4, 16'h0,    26'h0,    32'h0000_040C, 0, 0, 32'h0000_040C, 32'h0,     0, 32'h0,     0, 0);
        step("pop_empty", 1, 3'd4, 16'h0,    26'h0,    32'h0000_0410, 0, 0, 32'h0000_0410, 32'h0,     0, 32'h0,     0, 0);
        step("jr_hi",     1, 3'd4, 16'h0,    26'h0,    32'hF000_0100, 0, 0, 32'hF000_0100, 32'h0,     0, 32'h0,     0, 0);
        step("j_region",  1, 3'd2, 16'h0,    26'h10,   32'h0,         0, 0, 32'hF000_0040, 32'h0,     0, 32'h0,     0, 0);
        step("jr300",     1, 3'd4, 16'h0,    26'h0,    32'h0000_0300, 0, 0, 32'h0000_0300, 32'h0,     0, 32'h0,     0, 0);
        step("exc1",      0, 3'd0, 16'h0,    26'h0,    32'h0,         1, 0, 32'h0000_0180, 32'h300,   1, 32'h0,     0, 0);
        step("seq_in_exc",1, 3'd0, 16'h0,    26'h0,    32'h0,         0, 0, 32'h0000_0184, 32'h300,   1, 32'h0,     0, 0);
        step("exc2",      0, 3'd0, 16'h0,    26'h0,    32'h0,         1, 0, 32'h0000_0180, 32'h300,   1, 32'h0,     0, 0);
        step("eret",      0, 3'd0, 16'h0,    26'h0,    32'h0,         0, 1, 32'h0000_0300, 32'h300,   0, 32'h0,     0, 0);
        step("eret_norm", 0, 3'd0, 16'h0,    26'h0,    32'h0,         0, 1, 32'h0000_0300, 32'h300,   0, 32'h0,     0, 0);
        step("eret_nseq", 1, 3'd0, 16'h0,    26'h0,    32'h0,         0, 1, 32'h0000_0304, 32'h300,   0, 32'h0,     0, 0);
        step("jal_pre",   1, 3'd3, 16'h0,    26'h100,  32'h0,         0, 0, 32'h0000_0400, 32'h300,   0, 32'h308,   1, 0);
        step("exc_all",   1, 3'd3, 16'h0,    26'h200,  32'h0,         1, 1, 32'h0000_0180, 32'h400,   1, 32'h308,   1, 0);
        step("exc_eret",  0, 3'd0, 16'h0,    26'h0,    32'h0,         1, 1, 32'h0000_0180, 32'h400,   1, 32'h308,   1, 0);
        step("eret2",     0, 3'd0, 16'h0,    26'h0,    32'h0,         0, 1, 32'h0000_0400, 32'h400,   0, 32'h308,   1, 0);
        step("jr_misal",  1, 3'd4, 16'h0,    26'h0,    32'h0000_1003, 0, 0, 32'h0000_1000, 32'h400,   0, 32'h0,     0, 1);
        step("aerr_seq",  1, 3'd0, 16'h0,    26'h0,    32'h0,         0, 0, 32'h0000_1004, 32'h400,   0, 32'h0,     0, 1);
        step("aerr_jr",   1, 3'd4, 16'h0,    26'h0,    32'h0000_2000, 0, 0, 32'h0000_2000, 32'h400,   0, 32'h0,     0, 1);
        step("exc_pre",   0, 3'd0, 16'h0,    26'h0,    32'h0,         1, 0, 32'h0000_0180, 32'h2000,  1, 32'h0,     0, 1);

        // Asynchronous reset mid-run: asserted after an edge, checked before the next one.
        @(posedge clk); #1;
        rst = 1'b1;
        push_exp("rst_async", cyc_cnt, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        step("post_rst",  1, 3'd0, 16'h0,    26'h0,    32'h0,         0, 0, 32'h0000_0044, 32'h0,     0, 32'h0,     0, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
